// File: rtl/vx_tl_pkg.sv
// rtl/vx_tl_pkg.sv - TileLink opcode, size and source-width constants
package vx_tl_pkg;

  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam logic [3:0] SIZE_WORD = 4'd2;
  localparam int         SRC_WIDTH = 10;

  localparam logic [3:0] INTR_RESET_CYCLES = 4'd6;

endpackage

// File: rtl/vx_dcache_req_if_if.sv
// rtl/vx_dcache_req_if_if.sv - core request/response and TileLink A/D bundle
interface vx_dcache_req_if_if #(
  parameter int NUM_REQS   = 4,
  parameter int DTAG_WIDTH = 10,
  parameter int ITAG_WIDTH = 10,
  parameter int SRC_WIDTH  = 10
);
  logic [NUM_REQS-1:0]            dreq_valid, dreq_rw, dreq_ready;
  logic [4*NUM_REQS-1:0]          dreq_byteen;
  logic [30*NUM_REQS-1:0]         dreq_addr;
  logic [32*NUM_REQS-1:0]         dreq_data;
  logic [DTAG_WIDTH*NUM_REQS-1:0] dreq_tag;

  logic                           drsp_valid, drsp_ready;
  logic [NUM_REQS-1:0]            drsp_tmask;
  logic [32*NUM_REQS-1:0]         drsp_data;
  logic [DTAG_WIDTH-1:0]          drsp_tag;

  logic                           ireq_valid, ireq_ready;
  logic [29:0]                    ireq_addr;
  logic [ITAG_WIDTH-1:0]          ireq_tag;
  logic                           irsp_valid, irsp_ready;
  logic [31:0]                    irsp_data;
  logic [ITAG_WIDTH-1:0]          irsp_tag;

  logic [NUM_REQS-1:0]            dA_valid, dA_ready;
  logic [3*NUM_REQS-1:0]          dA_opcode;
  logic [4*NUM_REQS-1:0]          dA_size, dA_mask;
  logic [SRC_WIDTH*NUM_REQS-1:0]  dA_source;
  logic [32*NUM_REQS-1:0]         dA_address, dA_data;

  logic [NUM_REQS-1:0]            dD_valid, dD_ready;
  logic [3*NUM_REQS-1:0]          dD_opcode;
  logic [SRC_WIDTH*NUM_REQS-1:0]  dD_source;
  logic [32*NUM_REQS-1:0]         dD_data;

  logic                           iA_valid, iA_ready;
  logic [2:0]                     iA_opcode;
  logic [3:0]                     iA_size, iA_mask;
  logic [SRC_WIDTH-1:0]           iA_source;
  logic [31:0]                    iA_address, iA_data;

  logic                           iD_valid, iD_ready;
  logic [2:0]                     iD_opcode;
  logic [SRC_WIDTH-1:0]           iD_source;
  logic [31:0]                    iD_data;

  modport slave (
    input  dreq_valid, dreq_rw, dreq_byteen, dreq_addr, dreq_data, dreq_tag, drsp_ready,
    input  ireq_valid, ireq_addr, ireq_tag, irsp_ready,
    input  dA_ready, dD_valid, dD_opcode, dD_source, dD_data,
    input  iA_ready, iD_valid, iD_opcode, iD_source, iD_data,
    output dreq_ready, drsp_valid, drsp_tmask, drsp_data, drsp_tag,
    output ireq_ready, irsp_valid, irsp_data, irsp_tag,
    output dA_valid, dA_opcode, dA_size, dA_source, dA_address, dA_mask, dA_data, dD_ready,
    output iA_valid, iA_opcode, iA_size, iA_source, iA_address, iA_mask, iA_data, iD_ready
  );

  modport master (
    output dreq_valid, dreq_rw, dreq_byteen, dreq_addr, dreq_data, dreq_tag, drsp_ready,
    output ireq_valid, ireq_addr, ireq_tag, irsp_ready,
    output dA_ready, dD_valid, dD_opcode, dD_source, dD_data,
    output iA_ready, iD_valid, iD_opcode, iD_source, iD_data,
    input  dreq_ready, drsp_valid, drsp_tmask, drsp_data, drsp_tag,
    input  ireq_ready, irsp_valid, irsp_data, irsp_tag,
    input  dA_valid, dA_opcode, dA_size, dA_source, dA_address, dA_mask, dA_data, dD_ready,
    input  iA_valid, iA_opcode, iA_size, iA_source, iA_address, iA_mask, iA_data, iD_ready
  );

endinterface

// File: rtl/vx_intr_reset_gen.sv
// rtl/vx_intr_reset_gen.sv - stretches core reset for a fixed window after an msip rising edge
module vx_intr_reset_gen
  import vx_tl_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic msip,
  output logic core_reset
);

  logic       msip_q;
  logic [3:0] cnt_q, cnt_d;

  // msip history is kept through reset so a level held across reset is not seen as an edge
  always_ff @(posedge clock) begin
    msip_q <= msip;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (msip && !msip_q) begin
      cnt_d = INTR_RESET_CYCLES;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign core_reset = reset || (cnt_q != 4'd0);

endmodule

// File: rtl/vx_dcache_req_if.sv
// rtl/vx_dcache_req_if.sv - core cache ports to TileLink bridge; VX_HEAP_TRACE_EN enables store trace
module vx_dcache_req_if #(
  parameter int NUM_REQS   = 4,
  parameter int DTAG_WIDTH = 10,
  parameter int ITAG_WIDTH = 10,
  parameter int SRC_WIDTH  = vx_tl_pkg::SRC_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                msip,
  input  logic                core_busy,
  output logic                core_reset,
  output logic                cease,
  output logic                wfi,
  vx_dcache_req_if_if.slave   bus
);
  import vx_tl_pkg::*;

  logic [NUM_REQS-1:0] hit;
  logic                unused_ok;

  vx_intr_reset_gen u_intr_reset_gen (
    .clock      (clock),
    .reset      (reset),
    .msip       (msip),
    .core_reset (core_reset)
  );

  assign cease = !core_busy;
  assign wfi   = 1'b0;

  assign bus.iA_valid   = bus.ireq_valid;
  assign bus.iA_address = {bus.ireq_addr, 2'b00};
  assign bus.iA_source  = SRC_WIDTH'(bus.ireq_tag);
  assign bus.iA_opcode  = GET;
  assign bus.iA_size    = SIZE_WORD;
  assign bus.iA_mask    = 4'hF;
  assign bus.iA_data    = 32'd0;
  assign bus.ireq_ready = bus.iA_ready;

  assign bus.irsp_valid = bus.iD_valid;
  assign bus.irsp_data  = bus.iD_data;
  assign bus.irsp_tag   = bus.iD_source[ITAG_WIDTH-1:0];
  assign bus.iD_ready   = bus.irsp_ready;

  always_comb begin
    bus.dA_opcode  = '0;
    bus.dA_size    = '0;
    bus.dA_source  = '0;
    bus.dA_address = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (!bus.dreq_rw[i]) begin
        bus.dA_opcode[3*i +: 3] = GET;
      end else if (bus.dreq_byteen[4*i +: 4] == 4'hF) begin
        bus.dA_opcode[3*i +: 3] = PUT_FULL;
      end else begin
        bus.dA_opcode[3*i +: 3] = PUT_PARTIAL;
      end
      bus.dA_size[4*i +: 4]                = SIZE_WORD;
      bus.dA_source[SRC_WIDTH*i +: SRC_WIDTH] = SRC_WIDTH'(bus.dreq_tag[DTAG_WIDTH*i +: DTAG_WIDTH]);
      bus.dA_address[32*i +: 32]           = {bus.dreq_addr[30*i +: 30], 2'b00};
    end
  end

  assign bus.dA_valid   = bus.dreq_valid;
  assign bus.dA_mask    = bus.dreq_byteen;
  assign bus.dA_data    = bus.dreq_data;
  assign bus.dreq_ready = bus.dA_ready;

  // AccessAck carries no data back to the core, so write acks are dropped here
  always_comb begin
    hit          = '0;
    bus.drsp_tag = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      hit[i] = bus.dD_valid[i] && (bus.dD_opcode[3*i +: 3] != ACCESS_ACK);
      if (bus.dD_valid[i]) begin
        bus.drsp_tag = bus.dD_source[SRC_WIDTH*i +: DTAG_WIDTH];
      end
    end
  end

  assign bus.drsp_tmask = hit;
  assign bus.drsp_valid = |hit;
  assign bus.drsp_data  = bus.dD_data;
  assign bus.dD_ready   = {NUM_REQS{bus.drsp_ready}};

  assign unused_ok = ^{bus.iD_opcode, bus.iD_source, bus.dD_source};

`ifdef VX_HEAP_TRACE_EN
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (bus.dreq_valid[i] && bus.dreq_ready[i] && bus.dreq_rw[i]
          && bus.dA_address[32*i+28 +: 4] == 4'hC) begin
        $display("%0t heap store lane %0d addr %h data %h", $time, i,
                 bus.dA_address[32*i +: 32], bus.dreq_data[32*i +: 32]);
      end
    end
  end
`else
  // store trace compiled out
`endif

endmodule

// File: tb/tb_vx_dcache_req_if.sv
// tb/tb_vx_dcache_req_if.sv - randomized bench for vx_dcache_req_if against a lane-level model
module tb_vx_dcache_req_if;
  localparam int N  = 4;
  localparam int DT = 10;
  localparam int IT = 10;
  localparam int SW = 10;

  logic clock = 1'b0;
  logic reset, msip, core_busy;
  logic core_reset, cease, wfi;
  int   checks = 0;
  int   errors = 0;

  vx_dcache_req_if_if #(.NUM_REQS(N), .DTAG_WIDTH(DT), .ITAG_WIDTH(IT), .SRC_WIDTH(SW)) bus ();

  vx_dcache_req_if #(.NUM_REQS(N), .DTAG_WIDTH(DT), .ITAG_WIDTH(IT), .SRC_WIDTH(SW)) dut (
    .clock(clock), .reset(reset), .msip(msip), .core_busy(core_busy),
    .core_reset(core_reset), .cease(cease), .wfi(wfi), .bus(bus)
  );

  always #5 clock = ~clock;

  // lane-level stimulus
  logic        l_valid[N], l_rw[N], l_aready[N], l_dvalid[N];
  logic [3:0]  l_byteen[N];
  logic [29:0] l_addr[N];
  logic [31:0] l_data[N], l_ddata[N];
  logic [DT-1:0] l_tag[N];
  logic [2:0]  l_dop[N];
  logic [SW-1:0] l_dsrc[N];

  int   cyc, last_edge;
  logic prev_msip;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) begin
      bus.dreq_valid[i]           = l_valid[i];
      bus.dreq_rw[i]              = l_rw[i];
      bus.dreq_byteen[4*i +: 4]   = l_byteen[i];
      bus.dreq_addr[30*i +: 30]   = l_addr[i];
      bus.dreq_data[32*i +: 32]   = l_data[i];
      bus.dreq_tag[DT*i +: DT]    = l_tag[i];
      bus.dA_ready[i]             = l_aready[i];
      bus.dD_valid[i]             = l_dvalid[i];
      bus.dD_opcode[3*i +: 3]     = l_dop[i];
      bus.dD_source[SW*i +: SW]   = l_dsrc[i];
      bus.dD_data[32*i +: 32]     = l_ddata[i];
    end
  endtask

  task automatic randomize_lanes();
    for (int i = 0; i < N; i++) begin
      l_valid[i]  = 1'($urandom);
      l_rw[i]     = 1'($urandom);
      l_byteen[i] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      l_addr[i]   = 30'($urandom);
      l_data[i]   = $urandom;
      l_tag[i]    = DT'($urandom);
      l_aready[i] = 1'($urandom);
      l_dvalid[i] = 1'($urandom);
      l_dop[i]    = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
      l_dsrc[i]   = SW'($urandom);
      l_ddata[i]  = $urandom;
    end
  endtask

  // expected lane behaviour written from the bridge rules
  task automatic check_dcache();
    logic [N-1:0]      exp_hit;
    logic [DT-1:0]     exp_tag;
    logic [32*N-1:0]   exp_rdata;
    logic [2:0]        exp_op;
    exp_hit = '0;
    exp_tag = '0;
    for (int i = 0; i < N; i++) begin
      if (!l_rw[i])               exp_op = 3'd4;
      else if (l_byteen[i] == 4'hF) exp_op = 3'd0;
      else                        exp_op = 3'd1;
      check($sformatf("dA_valid%0d", i),  256'(bus.dA_valid[i]), 256'(l_valid[i]));
      check($sformatf("dA_opcode%0d", i), 256'(bus.dA_opcode[3*i +: 3]), 256'(exp_op));
      check($sformatf("dA_addr%0d", i),   256'(bus.dA_address[32*i +: 32]), 256'(l_addr[i]) * 4);
      check($sformatf("dA_source%0d", i), 256'(bus.dA_source[SW*i +: SW]), 256'(l_tag[i]));
      check($sformatf("dA_mask%0d", i),   256'(bus.dA_mask[4*i +: 4]), 256'(l_byteen[i]));
      check($sformatf("dA_data%0d", i),   256'(bus.dA_data[32*i +: 32]), 256'(l_data[i]));
      check($sformatf("dA_size%0d", i),   256'(bus.dA_size[4*i +: 4]), 256'(2));
      check($sformatf("dreq_ready%0d", i), 256'(bus.dreq_ready[i]), 256'(l_aready[i]));
      check($sformatf("dD_ready%0d", i),  256'(bus.dD_ready[i]), 256'(bus.drsp_ready));
      exp_hit[i] = l_dvalid[i] && (l_dop[i] != 3'd0);
      exp_rdata[32*i +: 32] = l_ddata[i];
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (l_dvalid[i]) begin
        exp_tag = l_dsrc[i][DT-1:0];
        break;
      end
    end
    check("drsp_tmask", 256'(bus.drsp_tmask), 256'(exp_hit));
    check("drsp_valid", 256'(bus.drsp_valid), 256'(exp_hit != 0));
    check("drsp_tag",   256'(bus.drsp_tag), 256'(exp_tag));
    check("drsp_data",  256'(bus.drsp_data), 256'(exp_rdata));
  endtask

  task automatic check_icache();
    check("iA_valid",   256'(bus.iA_valid), 256'(bus.ireq_valid));
    check("iA_address", 256'(bus.iA_address), 256'(bus.ireq_addr) * 4);
    check("iA_source",  256'(bus.iA_source), 256'(bus.ireq_tag));
    check("iA_opcode",  256'(bus.iA_opcode), 256'(4));
    check("iA_size",    256'(bus.iA_size), 256'(2));
    check("iA_mask",    256'(bus.iA_mask), 256'(15));
    check("iA_data",    256'(bus.iA_data), 256'(0));
    check("ireq_ready", 256'(bus.ireq_ready), 256'(bus.iA_ready));
    check("irsp_valid", 256'(bus.irsp_valid), 256'(bus.iD_valid));
    check("irsp_data",  256'(bus.irsp_data), 256'(bus.iD_data));
    check("irsp_tag",   256'(bus.irsp_tag), 256'(bus.iD_source % (1 << IT)));
    check("iD_ready",   256'(bus.iD_ready), 256'(bus.irsp_ready));
  endtask

  // one clock of reset/msip stimulus; core_reset is expected high while reset
  // is applied and for six cycles starting at the edge that sees an msip rise
  task automatic step(input logic r, input logic m);
    logic exp;
    reset = r;
    msip  = m;
    @(posedge clock);
    cyc++;
    if (r)                    last_edge = -100;
    else if (m && !prev_msip) last_edge = cyc;
    prev_msip = m;
    exp = r || (cyc - last_edge < 6);
    @(negedge clock);
    check($sformatf("core_reset@%0d", cyc), 256'(core_reset), 256'(exp));
  endtask

  initial begin
    reset = 1'b1; msip = 1'b0; core_busy = 1'b1;
    cyc = 0; last_edge = -100; prev_msip = 1'b0;
    randomize_lanes();
    drive_lanes();
    bus.drsp_ready = 1'b1;
    bus.ireq_valid = 1'b0; bus.ireq_addr = '0; bus.ireq_tag = '0; bus.irsp_ready = 1'b0;
    bus.iA_ready = 1'b0; bus.iD_valid = 1'b0; bus.iD_opcode = '0; bus.iD_source = '0; bus.iD_data = '0;
    @(negedge clock);

    for (int k = 0; k < 3; k++) step(1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
    for (int k = 0; k < 150; k++) step($urandom_range(0, 15) == 0, ($urandom_range(0, 3) == 0) ? ~prev_msip : prev_msip);
    step(1'b0, 1'b0);

    core_busy = 1'b0; #1;
    check("cease_idle", 256'(cease), 256'(1));
    core_busy = 1'b1; #1;
    check("cease_busy", 256'(cease), 256'(0));
    check("wfi", 256'(wfi), 256'(0));

    // directed lane checks
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      l_valid[i] = 1'b1; l_rw[i] = 1'b0; l_byteen[i] = 4'h0; l_dvalid[i] = 1'b0; l_dop[i] = 3'd0;
    end
    l_rw[2] = 1'b1; l_byteen[2] = 4'hF; l_addr[2] = 30'h100;
    l_rw[1] = 1'b1; l_byteen[1] = 4'h3;
    l_rw[0] = 1'b0; l_byteen[0] = 4'h5;
    l_dvalid[0] = 1'b1; l_dop[0] = 3'd1; l_dsrc[0] = SW'(32'h11);
    l_dvalid[2] = 1'b1; l_dop[2] = 3'd0; l_dsrc[2] = SW'(32'h22);
    drive_lanes();
    bus.drsp_ready = 1'b0;
    bus.ireq_addr = 30'h1; bus.ireq_tag = IT'(5); bus.iD_source = SW'(32'h3FF);
    #1;
    check("d_op2",    256'(bus.dA_opcode[8:6]), 256'(0));
    check("d_addr2",  256'(bus.dA_address[95:64]), 256'(32'h400));
    check("d_mask2",  256'(bus.dA_mask[11:8]), 256'(4'hF));
    check("d_size2",  256'(bus.dA_size[11:8]), 256'(2));
    check("d_op1",    256'(bus.dA_opcode[5:3]), 256'(1));
    check("d_op0",    256'(bus.dA_opcode[2:0]), 256'(4));
    check("d_mask0",  256'(bus.dA_mask[3:0]), 256'(4'h5));
    check("d_rvalid", 256'(bus.drsp_valid), 256'(1));
    check("d_tmask",  256'(bus.drsp_tmask), 256'(4'b0001));
    check("d_rtag",   256'(bus.drsp_tag), 256'(10'h22));
    check("d_dready", 256'(bus.dD_ready), 256'(0));
    check("i_addr",   256'(bus.iA_address), 256'(32'h4));
    check("i_src",    256'(bus.iA_source), 256'(5));
    check("i_op",     256'(bus.iA_opcode), 256'(4));
    check("i_rtag",   256'(bus.irsp_tag), 256'(10'h3FF));

    for (int it = 0; it < 200; it++) begin
      @(negedge clock);
      randomize_lanes();
      drive_lanes();
      bus.drsp_ready = 1'($urandom);
      bus.ireq_valid = 1'($urandom); bus.ireq_addr = 30'($urandom); bus.ireq_tag = IT'($urandom);
      bus.irsp_ready = 1'($urandom); bus.iA_ready = 1'($urandom); bus.iD_valid = 1'($urandom);
      bus.iD_opcode = 3'($urandom); bus.iD_source = SW'($urandom); bus.iD_data = $urandom;
      #1;
      check_dcache();
      check_icache();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
